// File: rtl/vec_check_driver.sv
// Stimulus driver and checker for pipelined lane-parallel vector add/sub DUTs.
// Drives deterministic operand vectors, delays expected results by LATENCY and compares against y.
module vec_check_driver #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned NUM_VEC      = 4,
  parameter int unsigned A_BASE       = 2,
  parameter int unsigned B_BASE       = 0,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   op,
  output logic                   en,
  output logic [LANES*WIDTH-1:0] a,
  output logic [LANES*WIDTH-1:0] b,
  input  logic [LANES*WIDTH-1:0] y,
  output logic                   fail,
  output logic                   finish,
  output logic [15:0]            err_count,
  output logic [15:0]            first_fail_idx
);

  localparam int unsigned VW = LANES * WIDTH;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [VW-1:0] gen_a(input logic [IW-1:0] idx);
    logic [VW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < LANES; i++)
      v[i*WIDTH +: WIDTH] = WIDTH'(A_BASE + 32'(idx) + i);
    return v;
  endfunction

  function automatic logic [VW-1:0] gen_b();
    logic [VW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < LANES; i++)
      v[i*WIDTH +: WIDTH] = WIDTH'(B_BASE - i);
    return v;
  endfunction

  logic [1:0]    state, state_n;
  logic          en_n;
  logic [VW-1:0] a_n, b_n;
  logic [IW-1:0] vec_idx, vec_idx_n;
  logic [CW-1:0] lat_cnt, lat_cnt_n;
  logic          op_r, op_r_n;
  logic          finish_n;
  logic [VW-1:0] exp_c;
  logic          flush_c;
  logic          chk_v;
  logic [VW-1:0] chk_exp;
  logic [IW-1:0] chk_idx;
  logic          mismatch_c;

  // Expected result for the vector currently on a/b
  always_comb begin
    exp_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (op_r)
        exp_c[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] - b[i*WIDTH +: WIDTH];
      else
        exp_c[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign chk_v   = en;
    assign chk_exp = exp_c;
    assign chk_idx = vec_idx;
  end else begin : g_pipe
    logic [LATENCY-1:0] pv;
    logic [VW-1:0]      pexp [LATENCY];
    logic [IW-1:0]      pidx [LATENCY];

    // Valid-tagged delay line; flushed on entry to DONE so in-flight vectors go unchecked
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pv <= '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
          pexp[i] <= '0;
          pidx[i] <= '0;
        end
      end else begin
        pv[0]   <= en && !flush_c;
        pexp[0] <= exp_c;
        pidx[0] <= vec_idx;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          pv[i]   <= pv[i-1] && !flush_c;
          pexp[i] <= pexp[i-1];
          pidx[i] <= pidx[i-1];
        end
      end
    end

    assign chk_v   = pv[LATENCY-1];
    assign chk_exp = pexp[LATENCY-1];
    assign chk_idx = pidx[LATENCY-1];
  end

  assign mismatch_c = chk_v && (state == S_DRIVE || state == S_DRAIN) && (y != chk_exp);
  assign flush_c    = (state_n == S_DONE);

  always_comb begin
    state_n   = state;
    en_n      = 1'b0;
    a_n       = a;
    b_n       = b;
    vec_idx_n = vec_idx;
    lat_cnt_n = lat_cnt;
    op_r_n    = op_r;
    finish_n  = finish;
    case (state)
      S_IDLE: begin
        op_r_n    = op;
        state_n   = S_DRIVE;
        en_n      = 1'b1;
        a_n       = gen_a(16'd0);
        b_n       = gen_b();
        vec_idx_n = '0;
      end
      S_DRIVE: begin
        if (vec_idx == IW'(NUM_VEC - 1)) begin
          state_n   = (LATENCY == 0) ? S_DONE : S_DRAIN;
          lat_cnt_n = '0;
        end else begin
          en_n      = 1'b1;
          vec_idx_n = vec_idx + 16'd1;
          a_n       = gen_a(vec_idx + 16'd1);
        end
      end
      S_DRAIN: begin
        if (lat_cnt == CW'(LATENCY - 1))
          state_n = S_DONE;
        else
          lat_cnt_n = lat_cnt + 4'd1;
      end
      S_DONE: begin
      end
      default: state_n = S_IDLE;
    endcase
    // Early termination holds operands where they were
    if (STOP_ON_FAIL != 0 && mismatch_c) begin
      state_n   = S_DONE;
      en_n      = 1'b0;
      a_n       = a;
      vec_idx_n = vec_idx;
    end
    if (state_n == S_DONE)
      finish_n = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      en      <= 1'b0;
      a       <= '0;
      b       <= '0;
      vec_idx <= '0;
      lat_cnt <= '0;
      op_r    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state   <= state_n;
      en      <= en_n;
      a       <= a_n;
      b       <= b_n;
      vec_idx <= vec_idx_n;
      lat_cnt <= lat_cnt_n;
      op_r    <= op_r_n;
      finish  <= finish_n;
    end
  end

  // Sticky result bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 16'hFFFF;
    end else if (mismatch_c) begin
      fail <= 1'b1;
      if (err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (first_fail_idx == 16'hFFFF)
        first_fail_idx <= chk_idx;
    end
  end

endmodule

// File: tb/tb_vec_check_driver.sv
// Bench for vec_check_driver: four configurations run side by side against a behavioural
// add/sub DUT with injectable faults; expectations come from an arithmetic reference model.
module tb_vec_check_driver;

  localparam int NI = 4;

  function automatic int p_lat(input int k);
    case (k) 0: return 1; 1: return 3; 2: return 0; default: return 1; endcase
  endfunction
  function automatic int p_nv(input int k);
    case (k) 0: return 4; 1: return 8; 2: return 8; default: return 6; endcase
  endfunction
  function automatic int p_a(input int k);
    case (k) 1: return 250; default: return 2; endcase
  endfunction
  function automatic int p_b(input int k);
    case (k) 1: return 10; default: return 0; endcase
  endfunction
  function automatic int p_stop(input int k);
    case (k) 3: return 1; default: return 0; endcase
  endfunction

  logic        clock;
  logic        reset;
  logic        op_drv [NI];
  logic        op_dut [NI];
  logic        en_w   [NI];
  logic [31:0] a_w    [NI];
  logic [31:0] b_w    [NI];
  logic [31:0] y_w    [NI];
  logic        fail_w [NI];
  logic        fin_w  [NI];
  logic [15:0] err_w  [NI];
  logic [15:0] ff_w   [NI];
  int          fmode  [NI];
  int          flane  [NI];
  int          fvec   [NI];
  int          e_fin  [NI];
  int          e_last [NI];
  int          e_err  [NI];
  int          e_ff   [NI];
  int          total;
  int          bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LT = p_lat(g);
    logic [15:0] cnt;
    logic [31:0] y_raw;
    logic [7:0]  lane_r;

    vec_check_driver #(
      .LANES(4), .WIDTH(8), .LATENCY(p_lat(g)), .NUM_VEC(p_nv(g)),
      .A_BASE(p_a(g)), .B_BASE(p_b(g)), .STOP_ON_FAIL(p_stop(g))
    ) u_dut (
      .clock(clock), .reset(reset), .op(op_drv[g]), .en(en_w[g]),
      .a(a_w[g]), .b(b_w[g]), .y(y_w[g]), .fail(fail_w[g]), .finish(fin_w[g]),
      .err_count(err_w[g]), .first_fail_idx(ff_w[g])
    );

    // Behavioural DUT: lane add/sub, optional stuck lane or single corrupted vector
    always @(posedge clock or posedge reset)
      if (reset) cnt <= '0;
      else if (en_w[g]) cnt <= cnt + 16'd1;

    always_comb begin
      y_raw  = '0;
      lane_r = '0;
      for (int i = 0; i < 4; i++) begin
        lane_r = op_dut[g] ? (a_w[g][i*8 +: 8] - b_w[g][i*8 +: 8])
                           : (a_w[g][i*8 +: 8] + b_w[g][i*8 +: 8]);
        if (fmode[g] == 1 && flane[g] == i) lane_r = 8'd0;
        if (fmode[g] == 2 && flane[g] == i && int'(cnt) == fvec[g]) lane_r = lane_r ^ 8'h5A;
        y_raw[i*8 +: 8] = lane_r;
      end
    end

    if (LT == 0) begin : g_z
      assign y_w[g] = y_raw;
    end else begin : g_d
      logic [31:0] yp [LT];
      always @(posedge clock) begin
        yp[0] <= y_raw;
        for (int i = 1; i < LT; i++) yp[i] <= yp[i-1];
      end
      assign y_w[g] = yp[LT-1];
    end
  end

  function automatic int lane_ref(input int k, input int v, input int i, input logic opx);
    int av, bv;
    av = (p_a(k) + v + i) & 255;
    bv = (p_b(k) - i) & 255;
    return opx ? ((av - bv) & 255) : ((av + bv) & 255);
  endfunction

  function automatic logic [31:0] vec_a(input int k, input int v);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((p_a(k) + v + i) & 255);
    return r;
  endfunction

  function automatic logic [31:0] vec_b(input int k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((p_b(k) - i) & 255);
    return r;
  endfunction

  function automatic bit vec_bad(input int k, input int v);
    case (fmode[k])
      1: return lane_ref(k, v, flane[k], op_dut[k]) != 0;
      2: return v == fvec[k];
      default: return 1'b0;
    endcase
  endfunction

  task automatic compute_exp();
    int first, nb;
    for (int k = 0; k < NI; k++) begin
      first = -1;
      nb = 0;
      for (int v = 0; v < p_nv(k); v++)
        if (vec_bad(k, v)) begin
          nb++;
          if (first < 0) first = v;
        end
      if (p_stop(k) != 0 && first >= 0) begin
        e_err[k]  = 1;
        e_fin[k]  = first + 2 + p_lat(k);
        e_last[k] = (e_fin[k] - 1 < p_nv(k)) ? e_fin[k] - 1 : p_nv(k);
      end else begin
        e_err[k]  = nb;
        e_fin[k]  = 1 + p_nv(k) + p_lat(k);
        e_last[k] = p_nv(k);
      end
      e_ff[k] = (first < 0) ? 'hFFFF : first;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d.rst_en", g), 32'(en_w[g]), 32'd0);
      chk($sformatf("u%0d.rst_a", g), a_w[g], 32'd0);
      chk($sformatf("u%0d.rst_b", g), b_w[g], 32'd0);
      chk($sformatf("u%0d.rst_fail", g), 32'(fail_w[g]), 32'd0);
      chk($sformatf("u%0d.rst_finish", g), 32'(fin_w[g]), 32'd0);
      chk($sformatf("u%0d.rst_err", g), 32'(err_w[g]), 32'd0);
      chk($sformatf("u%0d.rst_ffi", g), 32'(ff_w[g]), 32'hFFFF);
    end
  endtask

  task automatic check_cycle(input int kk);
    int last;
    for (int g = 0; g < NI; g++) begin
      last = e_last[g];
      chk($sformatf("u%0d.en k%0d", g, kk), 32'(en_w[g]), 32'(kk >= 1 && kk <= last));
      chk($sformatf("u%0d.a k%0d", g, kk), a_w[g],
          (kk == 0) ? 32'd0 : vec_a(g, ((kk < last) ? kk : last) - 1));
      chk($sformatf("u%0d.b k%0d", g, kk), b_w[g], (kk == 0) ? 32'd0 : vec_b(g));
      chk($sformatf("u%0d.finish k%0d", g, kk), 32'(fin_w[g]), 32'(kk >= e_fin[g]));
      if (kk >= e_fin[g]) begin
        chk($sformatf("u%0d.fail k%0d", g, kk), 32'(fail_w[g]), 32'(e_err[g] != 0));
        chk($sformatf("u%0d.err k%0d", g, kk), 32'(err_w[g]), 32'(e_err[g]));
        chk($sformatf("u%0d.ffi k%0d", g, kk), 32'(ff_w[g]), 32'(e_ff[g]));
      end
    end
  endtask

  task automatic setup(input int opsel, input int msel, input int lsel, input int vsel);
    for (int g = 0; g < NI; g++) begin
      op_dut[g] = (opsel < 0) ? 1'($urandom_range(1, 0)) : 1'(opsel);
      op_drv[g] = op_dut[g];
      fmode[g]  = (msel < 0) ? int'($urandom_range(2, 0)) : msel;
      flane[g]  = (lsel < 0) ? int'($urandom_range(3, 0)) : lsel;
      fvec[g]   = (vsel < 0) ? int'($urandom_range(p_nv(g) - 1, 0)) : vsel;
    end
  endtask

  task automatic run(input bit mid);
    int kmax;
    compute_exp();
    kmax = 0;
    for (int g = 0; g < NI; g++) if (e_fin[g] > kmax) kmax = e_fin[g];
    kmax += 3;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    if (mid) begin
      #1 check_cycle(0);
      for (int kk = 1; kk <= 3; kk++) begin
        @(negedge clock);
        check_cycle(kk);
      end
      // Asynchronous reset in the middle of DRIVE (vec_idx 2)
      #2 reset = 1'b1;
      #1 check_reset_vals();
      @(negedge clock);
      reset = 1'b0;
    end
    #1 check_cycle(0);
    for (int kk = 1; kk <= kmax; kk++) begin
      @(negedge clock);
      check_cycle(kk);
      // op must be ignored once the run has left IDLE
      for (int g = 0; g < NI; g++) op_drv[g] = 1'($urandom_range(1, 0));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    setup(0, 0, 0, 0);
    run(1'b0);                  // correct add
    setup(1, 0, 0, 0);
    run(1'b0);                  // correct sub
    setup(0, 1, 2, 0);
    run(1'b0);                  // lane 2 stuck at zero
    setup(0, 2, -1, 2);
    run(1'b0);                  // only vector 2 corrupted
    setup(-1, 0, 0, 0);
    run(1'b1);                  // reset mid-run then clean rerun
    for (int r = 0; r < 12; r++) begin
      setup(-1, -1, -1, -1);
      run(1'($urandom_range(1, 0)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
